// File: rtl/his_acq_sequencer.sv
// Histogram acquisition sequencer: per pixel, accumulates a coarse histogram,
// waits for its peak and the threshold calculation, then the fine histogram and its peak.
module his_acq_sequencer #(
    parameter int PIXEL_NUM = 4,
    parameter int SHOTS     = 16,
    parameter int NB        = 10,
    parameter int TO_CYC    = 255,
    localparam int PW       = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1
) (
    input  logic          clk,
    input  logic          res,
    input  logic          start,
    input  logic          stop,
    input  logic          laserSync,
    input  logic          evValid,
    input  logic          peakDone,
    input  logic [NB-1:0] peakCH,
    input  logic [NB-1:0] peakFH,
    input  logic          algebraicReady,
    output logic          wrEn,
    output logic          hisNum,
    output logic          acqCountFinish,
    output logic [PW-1:0] pixelIdx,
    output logic          resultValid,
    output logic [NB-1:0] resultCH,
    output logic [NB-1:0] resultFH,
    output logic          resultErr,
    output logic          busy,
    output logic          frameDone
);

    localparam int SW = (SHOTS > 1) ? $clog2(SHOTS) : 1;
    localparam int TW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [SW-1:0] SHOT_LAST = SW'(SHOTS - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYC - 1);
    localparam logic [PW-1:0] PIX_LAST  = PW'(PIXEL_NUM - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACQ_CH  = 3'd1,
        WAIT_CH = 3'd2,
        CALC    = 3'd3,
        ACQ_FH  = 3'd4,
        WAIT_FH = 3'd5,
        OUTPUT  = 3'd6
    } state_t;

    state_t        state_q, state_nxt;
    logic [SW-1:0] shot_cnt, shot_nxt;
    logic [TW-1:0] to_cnt, to_nxt;
    logic [PW-1:0] pix_nxt;
    logic [NB-1:0] ch_nxt, fh_nxt;
    logic          err_nxt;
    logic          timeout;

    assign busy   = (state_q != IDLE);
    assign hisNum = (state_q == ACQ_FH) || (state_q == WAIT_FH) || (state_q == OUTPUT);
    assign wrEn   = evValid && ((state_q == ACQ_CH) || (state_q == ACQ_FH));

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q   <= IDLE;
            shot_cnt  <= '0;
            to_cnt    <= '0;
            pixelIdx  <= '0;
            resultCH  <= '0;
            resultFH  <= '0;
            resultErr <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            shot_cnt  <= shot_nxt;
            to_cnt    <= to_nxt;
            pixelIdx  <= pix_nxt;
            resultCH  <= ch_nxt;
            resultFH  <= fh_nxt;
            resultErr <= err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state_q;
        shot_nxt       = shot_cnt;
        to_nxt         = to_cnt;
        pix_nxt        = pixelIdx;
        ch_nxt         = resultCH;
        fh_nxt         = resultFH;
        err_nxt        = resultErr;
        timeout        = 1'b0;
        acqCountFinish = 1'b0;
        resultValid    = 1'b0;
        frameDone      = 1'b0;

        // Abort outranks every other transition and suppresses the result/frame pulses.
        if (stop && (state_q != IDLE)) begin
            state_nxt = IDLE;
            shot_nxt  = '0;
            to_nxt    = '0;
            pix_nxt   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        state_nxt = ACQ_CH;
                        shot_nxt  = '0;
                        to_nxt    = '0;
                        pix_nxt   = '0;
                    end
                end
                ACQ_CH, ACQ_FH: begin
                    if (laserSync) begin
                        if (shot_cnt == SHOT_LAST) begin
                            acqCountFinish = 1'b1;
                            shot_nxt       = '0;
                            to_nxt         = '0;
                            if (state_q == ACQ_CH) begin
                                state_nxt = WAIT_CH;
                                ch_nxt    = '0;
                                fh_nxt    = '0;
                                err_nxt   = 1'b0;
                            end else begin
                                state_nxt = WAIT_FH;
                            end
                        end else begin
                            shot_nxt = shot_cnt + 1'b1;
                        end
                    end
                end
                WAIT_CH: begin
                    if (peakDone) begin
                        ch_nxt    = peakCH;
                        to_nxt    = '0;
                        state_nxt = CALC;
                    end else if (to_cnt == TO_LAST) begin
                        timeout = 1'b1;
                    end else begin
                        to_nxt = to_cnt + 1'b1;
                    end
                end
                CALC: begin
                    if (algebraicReady) begin
                        shot_nxt  = '0;
                        to_nxt    = '0;
                        state_nxt = ACQ_FH;
                    end else if (to_cnt == TO_LAST) begin
                        timeout = 1'b1;
                    end else begin
                        to_nxt = to_cnt + 1'b1;
                    end
                end
                WAIT_FH: begin
                    if (peakDone) begin
                        fh_nxt    = peakFH;
                        to_nxt    = '0;
                        state_nxt = OUTPUT;
                    end else if (to_cnt == TO_LAST) begin
                        timeout = 1'b1;
                    end else begin
                        to_nxt = to_cnt + 1'b1;
                    end
                end
                OUTPUT: begin
                    resultValid = 1'b1;
                    to_nxt      = '0;
                    if (pixelIdx == PIX_LAST) begin
                        pix_nxt   = '0;
                        frameDone = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        pix_nxt   = pixelIdx + 1'b1;
                        state_nxt = ACQ_CH;
                    end
                end
                default: state_nxt = IDLE;
            endcase

            // A missing peak or threshold result still reports the pixel, flagged and zeroed.
            if (timeout) begin
                err_nxt   = 1'b1;
                ch_nxt    = '0;
                fh_nxt    = '0;
                to_nxt    = '0;
                state_nxt = OUTPUT;
            end
        end
    end

endmodule

// File: tb/tb_his_acq_sequencer.sv
// Bench for his_acq_sequencer: randomized pixel scenarios with expected outputs
// derived from the scenario timing (shots, wait delays, timeouts, abort, reset).
module tb_his_acq_sequencer;

    localparam int PIXEL_NUM = 2;
    localparam int SHOTS     = 2;
    localparam int NB        = 10;
    localparam int TO_CYC    = 8;
    localparam int PW        = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1;

    logic          clk = 1'b0;
    logic          res;
    logic          start, stop, laserSync, evValid, peakDone, algebraicReady;
    logic [NB-1:0] peakCH, peakFH;
    logic          wrEn, hisNum, acqCountFinish, resultValid, resultErr, busy, frameDone;
    logic [PW-1:0] pixelIdx;
    logic [NB-1:0] resultCH, resultFH;

    int n_chk   = 0;
    int n_err   = 0;
    int exp_pix = 0;
    bit ev_force = 1'b0;

    his_acq_sequencer #(
        .PIXEL_NUM(PIXEL_NUM), .SHOTS(SHOTS), .NB(NB), .TO_CYC(TO_CYC)
    ) dut (
        .clk(clk), .res(res), .start(start), .stop(stop), .laserSync(laserSync),
        .evValid(evValid), .peakDone(peakDone), .peakCH(peakCH), .peakFH(peakFH),
        .algebraicReady(algebraicReady), .wrEn(wrEn), .hisNum(hisNum),
        .acqCountFinish(acqCountFinish), .pixelIdx(pixelIdx), .resultValid(resultValid),
        .resultCH(resultCH), .resultFH(resultFH), .resultErr(resultErr), .busy(busy),
        .frameDone(frameDone)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed still running, expected finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        start = 1'b0; stop = 1'b0; laserSync = 1'b0; evValid = 1'b0;
        peakDone = 1'b0; algebraicReady = 1'b0; peakCH = '0; peakFH = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        evValid = ev_force ? 1'b1 : 1'($urandom_range(0, 1));
        peakCH  = NB'($urandom);
        peakFH  = NB'($urandom);
        start   = 1'($urandom_range(0, 1));
    endtask

    task automatic check_common(input string tag, input bit exp_hn, input bit in_acq, input bit exp_acf);
        chk({tag, ".busy"}, 32'(busy), 32'(1));
        chk({tag, ".hisNum"}, 32'(hisNum), 32'(exp_hn));
        chk({tag, ".wrEn"}, 32'(wrEn), 32'(in_acq & evValid));
        chk({tag, ".acqFin"}, 32'(acqCountFinish), 32'(exp_acf));
        chk({tag, ".pix"}, 32'(pixelIdx), exp_pix);
        chk({tag, ".rv"}, 32'(resultValid), 32'(0));
        chk({tag, ".fd"}, 32'(frameDone), 32'(0));
    endtask

    task automatic acq_phase(input bit fine);
        for (int s = 0; s < SHOTS; s++) begin
            int gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                noise(); laserSync = 1'b0;
                peakDone = 1'($urandom_range(0, 1)); algebraicReady = 1'($urandom_range(0, 1));
                #1; check_common(fine ? "acq_fh" : "acq_ch", fine, 1'b1, 1'b0);
                next_cycle();
            end
            noise(); laserSync = 1'b1;
            peakDone = 1'($urandom_range(0, 1)); algebraicReady = 1'($urandom_range(0, 1));
            #1; check_common(fine ? "acq_fh_sync" : "acq_ch_sync", fine, 1'b1, s == SHOTS - 1);
            next_cycle();
        end
        laserSync = 1'b0; peakDone = 1'b0; algebraicReady = 1'b0;
    endtask

    // kind 0: coarse peak wait, 1: threshold calculation, 2: fine peak wait.
    // The awaited input arrives on cycle d; d > TO_CYC means it never arrives.
    task automatic wait_phase(input int kind, input int d, input int force_val,
                              output bit timed_out, output logic [NB-1:0] val);
        timed_out = 1'b1;
        val = '0;
        for (int c = 1; c <= TO_CYC; c++) begin
            bit arrival = (c == d);
            noise(); laserSync = 1'($urandom_range(0, 1));
            if (kind == 1) begin
                algebraicReady = arrival; peakDone = 1'($urandom_range(0, 1));
            end else begin
                peakDone = arrival; algebraicReady = 1'($urandom_range(0, 1));
            end
            if (arrival && force_val >= 0) begin
                if (kind == 0) peakCH = NB'(force_val);
                else peakFH = NB'(force_val);
            end
            #1;
            check_common(kind == 0 ? "wait_ch" : (kind == 1 ? "calc" : "wait_fh"), kind == 2, 1'b0, 1'b0);
            if (kind == 0 && c == 1) begin
                chk("wait_ch_entry.ch", 32'(resultCH), 32'(0));
                chk("wait_ch_entry.fh", 32'(resultFH), 32'(0));
                chk("wait_ch_entry.err", 32'(resultErr), 32'(0));
            end
            if (arrival) begin
                timed_out = 1'b0;
                val = (kind == 2) ? peakFH : peakCH;
            end
            next_cycle();
            if (arrival) break;
        end
        peakDone = 1'b0; algebraicReady = 1'b0; laserSync = 1'b0;
    endtask

    task automatic output_phase(input bit err, input logic [NB-1:0] ch, input logic [NB-1:0] fh);
        bit last = (exp_pix == PIXEL_NUM - 1);
        noise(); #1;
        chk("out.rv", 32'(resultValid), 32'(1));
        chk("out.err", 32'(resultErr), 32'(err));
        chk("out.ch", 32'(resultCH), 32'(ch));
        chk("out.fh", 32'(resultFH), 32'(fh));
        chk("out.hisNum", 32'(hisNum), 32'(1));
        chk("out.busy", 32'(busy), 32'(1));
        chk("out.wrEn", 32'(wrEn), 32'(0));
        chk("out.fd", 32'(frameDone), 32'(last));
        if (!last) chk("out.pix", 32'(pixelIdx), exp_pix);
        next_cycle();
        exp_pix = last ? 0 : exp_pix + 1;
        idle_inputs(); #1;
        chk("hold.ch", 32'(resultCH), 32'(ch));
        chk("hold.fh", 32'(resultFH), 32'(fh));
        chk("hold.err", 32'(resultErr), 32'(err));
        chk("after_out.pix", 32'(pixelIdx), exp_pix);
        chk("after_out.busy", 32'(busy), 32'(!last));
        chk("after_out.rv", 32'(resultValid), 32'(0));
    endtask

    task automatic run_pixel(input int dch, input int dcalc, input int dfh, input int fch, input int ffh);
        bit to;
        bit err;
        logic [NB-1:0] ch, fh, dummy;
        fh = '0;
        acq_phase(1'b0);
        wait_phase(0, dch, fch, to, ch);
        err = to;
        if (!err) begin
            wait_phase(1, dcalc, -1, to, dummy);
            err = to;
        end
        if (!err) begin
            acq_phase(1'b1);
            wait_phase(2, dfh, ffh, to, fh);
            err = to;
        end
        if (err) begin
            ch = '0;
            fh = '0;
        end
        output_phase(err, ch, fh);
    endtask

    task automatic start_frame();
        idle_inputs(); start = 1'b1; #1;
        chk("start.busy", 32'(busy), 32'(0));
        chk("start.pix", 32'(pixelIdx), 32'(0));
        next_cycle();
        start = 1'b0;
        exp_pix = 0;
    endtask

    function automatic int rnd_ok();
        return $urandom_range(1, TO_CYC);
    endfunction

    function automatic int rnd_any();
        return $urandom_range(1, TO_CYC + 2);
    endfunction

    initial begin
        bit to;
        logic [NB-1:0] v;

        // Reset state, with start and events asserted during reset
        idle_inputs();
        res = 1'b0; evValid = 1'b1; start = 1'b1;
        next_cycle(); next_cycle();
        chk("rst.busy", 32'(busy), 32'(0));
        chk("rst.wrEn", 32'(wrEn), 32'(0));
        chk("rst.hisNum", 32'(hisNum), 32'(0));
        chk("rst.acqFin", 32'(acqCountFinish), 32'(0));
        chk("rst.pix", 32'(pixelIdx), 32'(0));
        chk("rst.rv", 32'(resultValid), 32'(0));
        chk("rst.ch", 32'(resultCH), 32'(0));
        chk("rst.fh", 32'(resultFH), 32'(0));
        chk("rst.err", 32'(resultErr), 32'(0));
        chk("rst.fd", 32'(frameDone), 32'(0));
        idle_inputs(); res = 1'b1;
        next_cycle();

        // start together with stop in IDLE stays IDLE
        start = 1'b1; stop = 1'b1; next_cycle();
        idle_inputs(); #1;
        chk("start_stop.busy", 32'(busy), 32'(0));
        next_cycle();

        // Nominal frame, peaks 5/9 on pixel 0 with events held high
        start_frame();
        ev_force = 1'b1;
        run_pixel(3, 2, 4, 5, 9);
        ev_force = 1'b0;
        run_pixel(rnd_ok(), rnd_ok(), rnd_ok(), -1, -1);
        next_cycle();
        chk("idle_after_frame.busy", 32'(busy), 32'(0));

        // Coarse timeout, then every awaited input on the last allowed cycle
        start_frame();
        run_pixel(TO_CYC + 1, 1, 1, -1, -1);
        run_pixel(TO_CYC, TO_CYC, TO_CYC, -1, -1);

        // Calculation timeout, then fine peak timeout
        start_frame();
        run_pixel(1, TO_CYC + 1, 1, -1, -1);
        run_pixel(2, 3, TO_CYC + 2, -1, -1);

        // Random frames
        for (int f = 0; f < 4; f++) begin
            start_frame();
            for (int p = 0; p < PIXEL_NUM; p++)
                run_pixel(rnd_any(), rnd_any(), rnd_any(), -1, -1);
        end

        // Abort during the fine acquisition of pixel 1
        start_frame();
        run_pixel(rnd_ok(), rnd_ok(), rnd_ok(), -1, -1);
        acq_phase(1'b0);
        wait_phase(0, 2, -1, to, v);
        wait_phase(1, 1, -1, to, v);
        noise(); laserSync = 1'b1; #1;
        check_common("stop_pre", 1'b1, 1'b1, 1'b0);
        next_cycle();
        noise(); laserSync = 1'b1; stop = 1'b1; #1;
        chk("stop.rv", 32'(resultValid), 32'(0));
        chk("stop.fd", 32'(frameDone), 32'(0));
        next_cycle();
        idle_inputs(); #1;
        chk("stop_after.busy", 32'(busy), 32'(0));
        chk("stop_after.pix", 32'(pixelIdx), 32'(0));
        chk("stop_after.hisNum", 32'(hisNum), 32'(0));
        chk("stop_after.rv", 32'(resultValid), 32'(0));
        chk("stop_after.fd", 32'(frameDone), 32'(0));
        next_cycle();
        chk("stop_idle.busy", 32'(busy), 32'(0));
        start_frame();
        for (int p = 0; p < PIXEL_NUM; p++)
            run_pixel(rnd_ok(), rnd_ok(), rnd_ok(), -1, -1);

        // Asynchronous reset during WAIT_FH of pixel 1
        start_frame();
        run_pixel(rnd_ok(), rnd_ok(), rnd_ok(), -1, -1);
        acq_phase(1'b0);
        wait_phase(0, 1, 7, to, v);
        wait_phase(1, 1, -1, to, v);
        acq_phase(1'b1);
        noise(); peakDone = 1'b0; #1;
        check_common("wait_fh_pre_rst", 1'b1, 1'b0, 1'b0);
        next_cycle();
        idle_inputs(); evValid = 1'b1; start = 1'b1;
        #2; res = 1'b0; #1;
        chk("arst.busy", 32'(busy), 32'(0));
        chk("arst.wrEn", 32'(wrEn), 32'(0));
        chk("arst.hisNum", 32'(hisNum), 32'(0));
        chk("arst.pix", 32'(pixelIdx), 32'(0));
        chk("arst.rv", 32'(resultValid), 32'(0));
        chk("arst.ch", 32'(resultCH), 32'(0));
        chk("arst.fh", 32'(resultFH), 32'(0));
        chk("arst.err", 32'(resultErr), 32'(0));
        chk("arst.fd", 32'(frameDone), 32'(0));
        chk("arst.acqFin", 32'(acqCountFinish), 32'(0));
        next_cycle(); next_cycle();
        chk("arst_start.busy", 32'(busy), 32'(0));
        idle_inputs(); next_cycle();
        res = 1'b1;
        next_cycle();
        chk("post_rst.busy", 32'(busy), 32'(0));
        start_frame();
        for (int p = 0; p < PIXEL_NUM; p++)
            run_pixel(rnd_ok(), rnd_ok(), rnd_ok(), -1, -1);
        next_cycle();
        chk("final.busy", 32'(busy), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/his_acq_sequencer.md
HIS_ACQ_SEQUENCER -- requirements
Module: his_acq_sequencer

Interface
REQ-001 Parameter PIXEL_NUM, default 4: pixels sequenced per frame (≥1).
REQ-002 Parameter SHOTS, default 16: laser periods accumulated per histogram (≥1).
REQ-003 Parameter NB, default 10: width of peak bin indices.
REQ-004 Parameter TO_CYC, default 255: wait-state timeout in cycles (≥1).
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 res  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  one-cycle frame start request.
REQ-008 stop  in  1  abort request.
REQ-009 laserSync  in  1  one-cycle pulse per laser period.
REQ-010 evValid  in  1  TDC event present this cycle.
REQ-011 peakDone  in  1  peak detector result valid.
REQ-012 peakCH / peakFH  in  NB each  coarse / fine peak indices.
REQ-013 algebraicReady  in  1  threshold calculation complete.
REQ-014 wrEn  out  1  histogram write enable.
REQ-015 hisNum  out  1  0 = coarse histogram, 1 = fine histogram.
REQ-016 acqCountFinish  out  1  one-cycle end-of-accumulation pulse.
REQ-017 pixelIdx  out  clog2(PIXEL_NUM), minimum 1 bit  current pixel.
REQ-018 resultValid  out  1; resultCH, resultFH  out  NB; resultErr  out  1  per-pixel result.
REQ-019 busy  out  1; frameDone  out  1  one-cycle pulse.

Function
REQ-020 States: IDLE, ACQ_CH, WAIT_CH, CALC, ACQ_FH, WAIT_FH, OUTPUT. Binary encoding; state register is reset to IDLE.
REQ-021 IDLE: start=1 -> ACQ_CH next cycle; pixelIdx, shot counter and timeout counter cleared.
REQ-022 busy = (state != IDLE).
REQ-023 hisNum = 1 in ACQ_FH, WAIT_FH and OUTPUT; 0 in all other states.
REQ-024 wrEn = evValid & (state==ACQ_CH | state==ACQ_FH), combinational, zero latency.
REQ-025 In ACQ_*: each laserSync increments the shot counter. laserSync with counter==SHOTS-1 then:
- asserts acqCountFinish the same cycle (registered into the next cycle is not permitted);
- clears the counter;
- moves ACQ_CH->WAIT_CH or ACQ_FH->WAIT_FH.
REQ-026 An event coincident with the final laserSync is written (wrEn=1); events in WAIT/CALC/OUTPUT/IDLE are dropped.
REQ-027 WAIT_CH: peakDone=1 -> capture peakCH into resultCH, go CALC.
REQ-028 CALC: algebraicReady=1 -> ACQ_FH; the shot counter is 0 on entry.
REQ-029 WAIT_FH: peakDone=1 -> capture peakFH into resultFH, go OUTPUT.
REQ-030 Timeout counter:
- cleared on entry to WAIT_CH, CALC or WAIT_FH;
- increments each cycle spent in those states;
- reaching TO_CYC without the awaited input -> resultErr=1, resultCH and resultFH zeroed, go OUTPUT.
REQ-031 An awaited input arriving on the timeout cycle wins: no error.
REQ-032 OUTPUT (one cycle): resultValid=1, results held stable.
- pixelIdx<PIXEL_NUM-1: pixelIdx+1, next state ACQ_CH.
- Otherwise: pixelIdx wraps to 0, frameDone=1 same cycle, next state IDLE.
REQ-033 resultErr, resultCH and resultFH hold their values until the next WAIT_CH entry, where they clear to 0.
REQ-034 stop=1 in any non-IDLE state -> IDLE next cycle:
- counters and pixelIdx cleared;
- no resultValid or frameDone is issued;
- stop has priority over every other transition.
REQ-035 start while busy is ignored; start and stop together in IDLE: remain IDLE.
REQ-036 peakDone or algebraicReady outside its awaited state is ignored.

Reset
REQ-037 res=0 forces IDLE asynchronously and clears all outputs and internal registers to 0, including wrEn, which is gated by state.
REQ-038 Deassertion of res takes effect at the next rising clk edge; reset mid-acquisition discards the partial pixel.

Verification
REQ-039 PIXEL_NUM=2, SHOTS=2: start, 2 laserSync, peakDone (peakCH=5), algebraicReady, 2 laserSync, peakDone (peakFH=9) -> resultValid with 5/9, resultErr=0; second pixel follows, then frameDone with pixelIdx=0 and return to IDLE.
REQ-040 evValid held high through ACQ_CH and WAIT_CH -> wrEn high only in ACQ_CH, including the final-laserSync cycle; acqCountFinish is exactly one pulse.
REQ-041 No peakDone in WAIT_CH, TO_CYC=8 -> OUTPUT after 8 cycles with resultErr=1 and resultCH=resultFH=0; peakDone on cycle 8 -> no error.
REQ-042 stop during ACQ_FH of pixel 1 -> IDLE next cycle, pixelIdx=0, no resultValid or frameDone; a new start then runs a clean frame.
REQ-043 res pulled low during WAIT_FH (asynchronous, between clk edges) -> all outputs 0 immediately; start ignored while res=0.
